// File: rtl/icache_line_refill_pkg.sv
// Shared I-cache refill types and constants: FSM state enum,
// AXI-style response code, default line/offset geometry helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  localparam int unsigned IC_DATA_WIDTH = 32;
  localparam int unsigned IC_BLOCK_SIZE = 32;
  localparam int unsigned IC_LINE_BITS =
    IC_DATA_WIDTH * IC_BLOCK_SIZE;
  localparam int unsigned IC_OFFSET_WIDTH =
    $clog2(IC_LINE_BITS / 8);

  function automatic int unsigned cnt_width(
    input int unsigned n
  );
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/icache_line_refill_line_assembler.sv
// Beat counter and line register for the refill engine.
// Ports: CLK, RST, clr (zero counter), beat_valid/beat_data (accepted
// beat), line (assembled line, beat 0 in LSBs), last_beat (cnt==BEATS-1).
module line_assembler
  import icache_pkg::*;
#(
  parameter int MEM_WIDTH = 32,
  parameter int BEATS     = 32,
  parameter int CNT_W     = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       clr,
  input  logic                       beat_valid,
  input  logic [MEM_WIDTH-1:0]       beat_data,
  output logic [BEATS*MEM_WIDTH-1:0] line,
  output logic                       last_beat
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (beat_valid) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The line is not cleared on a new request: the previous line stays
  // visible until the first beat of the next fill overwrites it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      line <= '0;
    end else if (beat_valid) begin
      line[int'(cnt)*MEM_WIDTH +: MEM_WIDTH] <= beat_data;
    end
  end

  assign last_beat = (cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_line_refill.sv
// I-cache line-fill engine: one incrementing read burst per miss,
// beats assembled into a line returned as a one-cycle LINE_VALID pulse.
// Ports: REQ_* miss request, LINE_* line return, BUSY, MEM_AR*/MEM_R*
// read channel, ACCESS_ERR error pulse.
// Build option: ICACHE_REFILL_ERR_EN turns a non-OKAY beat into an
// ACCESS_ERR pulse in place of LINE_VALID; otherwise RRESP is ignored.
module icache_line_refill
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int MEM_WIDTH  = 32,
  localparam int LINE_BITS    = BLOCK_SIZE * DATA_WIDTH,
  localparam int OFFSET_WIDTH = $clog2(LINE_BITS / 8),
  localparam int BEATS        = LINE_BITS / MEM_WIDTH,
  localparam int BEAT_CNT_W   = cnt_width(BEATS),
  localparam int RA_W         = ADDR_WIDTH - OFFSET_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  input  logic [RA_W-1:0]       REQ_ADDR,
  output logic                  LINE_VALID,
  output logic [LINE_BITS-1:0]  LINE_DATA,
  output logic                  BUSY,
  output logic                  MEM_ARVALID,
  input  logic                  MEM_ARREADY,
  output logic [ADDR_WIDTH-1:0] MEM_ARADDR,
  output logic [7:0]            MEM_ARLEN,
  input  logic                  MEM_RVALID,
  output logic                  MEM_RREADY,
  input  logic [MEM_WIDTH-1:0]  MEM_RDATA,
  input  logic                  MEM_RLAST,
  input  logic [1:0]            MEM_RRESP,
  output logic                  ACCESS_ERR
);

  refill_state_t state;
  logic          accept;
  logic          beat;
  logic          last_beat;
  logic          fill_done;
  logic          err_nxt;

  assign accept    = (state == IDLE) && REQ_VALID;
  assign beat      = (state == DATA) && MEM_RREADY && MEM_RVALID;
  // The beat counter decides the end of the burst; RLAST is ignored.
  assign fill_done = beat && last_beat;
  assign BUSY      = (state != IDLE);
  assign MEM_ARLEN = 8'(BEATS - 1);

`ifdef ICACHE_REFILL_ERR_EN
  logic err_q;
  logic unused_rlast;

  assign unused_rlast = MEM_RLAST;
  assign err_nxt = err_q ||
    (beat && (MEM_RRESP != RRESP_OKAY));

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ACCESS_ERR <= 1'b0;
    end else begin
      ACCESS_ERR <= fill_done && err_nxt;
    end
  end
`else
  logic unused_rsp;

  assign unused_rsp = ^{MEM_RLAST, MEM_RRESP};
  assign err_nxt    = 1'b0;
  assign ACCESS_ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      LINE_VALID <= 1'b0;
    end else begin
      LINE_VALID <= fill_done && !err_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      MEM_ARVALID <= 1'b0;
      MEM_ARADDR  <= '0;
      MEM_RREADY  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (REQ_VALID) begin
            MEM_ARADDR  <=
              {REQ_ADDR, {OFFSET_WIDTH{1'b0}}};
            MEM_ARVALID <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (MEM_ARREADY) begin
            MEM_ARVALID <= 1'b0;
            MEM_RREADY  <= 1'b1;
            state       <= DATA;
          end
        end
        DATA: begin
          if (fill_done) begin
            MEM_RREADY <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  line_assembler #(
    .MEM_WIDTH (MEM_WIDTH),
    .BEATS     (BEATS),
    .CNT_W     (BEAT_CNT_W)
  ) u_asm (
    .CLK        (CLK),
    .RST        (RST),
    .clr        (accept),
    .beat_valid (beat),
    .beat_data  (MEM_RDATA),
    .line       (LINE_DATA),
    .last_beat  (last_beat)
  );

endmodule
